// File: rtl/instr_exec.sv
// instr_exec: a tiny 4-register, 8-word program sequencer.
// Each instruction takes one FETCH cycle to latch the memory word and one EXEC cycle to retire it.
module instr_exec #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [2:0]     adr,
    input  logic [3*N+2:0] instr,
    input  logic [1:0]     dbg_sel,
    output logic [N-1:0]   dbg_data,
    output logic           busy,
    output logic           done,
    output logic           carry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOVR = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       pc_q, pc_d;
    logic [3*N+2:0]   ir_q, ir_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     regs_q [4];
    logic [N-1:0]     regs_d [4];

    // Decoded fields of the latched instruction; only the low two bits of a
    // register field select a register, the full src1 field is the immediate.
    logic [2:0]       op;
    logic [1:0]       dest_idx;
    logic [1:0]       src1_idx;
    logic [1:0]       src2_idx;
    logic [N-1:0]     imm;
    logic [N-1:0]     opa;
    logic [N-1:0]     opb;
    logic [N:0]       sum;
    logic [N:0]       diff;

    assign op       = ir_q[3*N+2:3*N];
    assign dest_idx = ir_q[2*N+1:2*N];
    assign src1_idx = ir_q[N+1:N];
    assign src2_idx = ir_q[1:0];
    assign imm      = ir_q[2*N-1:N];
    assign opa      = regs_q[src1_idx];
    assign opb      = regs_q[src2_idx];
    assign sum      = {1'b0, opa} + {1'b0, opb};
    assign diff     = {1'b0, opa} - {1'b0, opb};

    // Upper register-select bits are architecturally ignored.
    logic unused_field_bits;
    assign unused_field_bits = &{1'b0, ir_q[3*N-1:2*N+2], ir_q[N-1:2]};

    assign adr      = pc_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign done     = (state_q == S_DONE);
    assign carry    = carry_q;
    assign dbg_data = regs_q[dbg_sel];

    // Next-state, PC, instruction latch and execute datapath.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = 3'd0;
                    carry_d = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        regs_d[i] = '0;
                    end
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_MOVI: regs_d[dest_idx] = imm;
                    OP_MOVR: regs_d[dest_idx] = opa;
                    OP_ADD: begin
                        regs_d[dest_idx] = sum[N-1:0];
                        carry_d          = sum[N];
                    end
                    OP_SUB: begin
                        regs_d[dest_idx] = diff[N-1:0];
                        carry_d          = diff[N];
                    end
                    OP_AND:  regs_d[dest_idx] = opa & opb;
                    OP_OR:   regs_d[dest_idx] = opa | opb;
                    OP_NOP:  ;
                    OP_HALT: ;
                    default: ;
                endcase
                // Address 7 is the last word: the PC never wraps within a run.
                if ((op == OP_HALT) || (pc_q == 3'd7)) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 3'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, PC, instruction register and carry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= 3'd0;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    // Register file, one flop bank per register.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg
            // Register gi updates from the execute datapath.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec: the driver pushes the expected end-of-run
// state when it issues start; the monitor pops and compares on each done pulse.
module tb_instr_exec;

    localparam int N = 8;
    localparam int W = 3 * N + 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     adr;
    logic [W-1:0]   instr;
    logic [1:0]     dbg_sel;
    logic [N-1:0]   dbg_data;
    logic           busy;
    logic           done;
    logic           carry;

    logic [W-1:0]   prog [8];
    logic [1:0]     drv_sel = 2'd0;
    logic [1:0]     mon_sel = 2'd0;
    logic           drv_active = 1'b0;

    typedef struct packed {
        logic [3:0][N-1:0] r;
        logic              c;
        logic [31:0]       cycles;
        logic [2:0]        last_adr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;

    assign instr   = prog[adr];
    assign dbg_sel = drv_active ? drv_sel : mon_sel;

    always #5 clk = ~clk;

    instr_exec #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .adr      (adr),
        .instr    (instr),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .busy     (busy),
        .done     (done),
        .carry    (carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic [2:0] op, input logic [7:0] d,
                                         input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    function automatic exp_t mk(input logic [7:0] r0, input logic [7:0] r1,
                                input logic [7:0] r2, input logic [7:0] r3,
                                input logic c, input int cyc, input logic [2:0] a);
        exp_t e;
        e.r        = {r3, r2, r1, r0};
        e.c        = c;
        e.cycles   = cyc;
        e.last_adr = a;
        return e;
    endfunction

    // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    check("done_expected", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("final_adr", adr, e.last_adr);
                        check("carry", carry, e.c);
                        check("busy_cycles", busy_cnt, e.cycles);
                        for (int i = 0; i < 4; i++) begin
                            mon_sel = i[1:0];
                            #1;
                            $display("run end: r%0d=%0d expected %0d", i, dbg_data, e.r[i]);
                            check($sformatf("reg%0d", i), dbg_data, e.r[i]);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = '0;
    endtask

    task automatic load_default();
        clear_prog();
        prog[0] = enc(3'b000, 8'd0, 8'd5, 8'd0);
        prog[1] = enc(3'b000, 8'd1, 8'd7, 8'd0);
        prog[2] = enc(3'b010, 8'd2, 8'd0, 8'd1);
    endtask

    task automatic wait_done(input int limit);
        int  n = 0;
        logic got = 1'b0;
        while (!got && n < limit) begin
            @(negedge clk);
            if (done) got = 1'b1;
            n++;
        end
        check("done_within_bound", got, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input exp_t e);
        sb_q.push_back(e);
        pulse_start();
        wait_done(40);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_adr"}, adr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_carry"}, carry, 0);
        drv_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv_sel = i[1:0];
            #1;
            check($sformatf("%s_reg%0d", tag, i), dbg_data, 0);
        end
        drv_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_prog();
        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Default program, full 8-word run.
        load_default();
        run(mk(8'd0, 8'd7, 8'd12, 8'd0, 1'b0, 16, 3'd7));

        // ADD overflow, HALT at 3.
        clear_prog();
        prog[0] = enc(3'b000, 8'd0, 8'd200, 8'd0);
        prog[1] = enc(3'b000, 8'd1, 8'd100, 8'd0);
        prog[2] = enc(3'b010, 8'd2, 8'd0, 8'd1);
        prog[3] = enc(3'b111, 8'd0, 8'd0, 8'd0);
        run(mk(8'd200, 8'd100, 8'd44, 8'd0, 1'b1, 8, 3'd3));

        // AND/OR leave the carry from the ADD untouched; NOP; HALT at 6.
        prog[3] = enc(3'b100, 8'd3, 8'd0, 8'd1);
        prog[4] = enc(3'b101, 8'd0, 8'd0, 8'd1);
        prog[5] = enc(3'b110, 8'd2, 8'd0, 8'd0);
        prog[6] = enc(3'b111, 8'd0, 8'd0, 8'd0);
        run(mk(8'd236, 8'd100, 8'd44, 8'd64, 1'b1, 14, 3'd6));

        // SUB with borrow.
        clear_prog();
        prog[0] = enc(3'b000, 8'd0, 8'd3, 8'd0);
        prog[1] = enc(3'b000, 8'd1, 8'd5, 8'd0);
        prog[2] = enc(3'b011, 8'd2, 8'd0, 8'd1);
        prog[3] = enc(3'b111, 8'd0, 8'd0, 8'd0);
        run(mk(8'd3, 8'd5, 8'd254, 8'd0, 1'b1, 8, 3'd3));

        // SUB without borrow.
        prog[2] = enc(3'b011, 8'd3, 8'd1, 8'd0);
        run(mk(8'd3, 8'd5, 8'd0, 8'd2, 1'b0, 8, 3'd3));

        // dest==src doubling, MOVR, dest field 0x05 selects r1.
        clear_prog();
        prog[0] = enc(3'b000, 8'h05, 8'd6, 8'd0);
        prog[1] = enc(3'b010, 8'd1, 8'd1, 8'd1);
        prog[2] = enc(3'b001, 8'd3, 8'd1, 8'd0);
        prog[3] = enc(3'b111, 8'd0, 8'd0, 8'd0);
        run(mk(8'd0, 8'd12, 8'd0, 8'd12, 1'b0, 8, 3'd3));

        // Asynchronous reset during EXEC of address 2 aborts without done.
        load_default();
        pulse_start();
        begin
            int n = 0;
            while (!(busy && adr == 3'd2) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("reached_adr2", adr, 2);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        run(mk(8'd0, 8'd7, 8'd12, 8'd0, 1'b0, 16, 3'd7));

        // start held high for a whole run: exactly one run.
        sb_q.push_back(mk(8'd0, 8'd7, 8'd12, 8'd0, 1'b0, 16, 3'd7));
        @(negedge clk);
        start = 1'b1;
        wait_done(40);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_rerun_busy", busy, 0);
        end
        // A fresh start in IDLE begins a new run.
        run(mk(8'd0, 8'd7, 8'd12, 8'd0, 1'b0, 16, 3'd7));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 SHALL have parameter N, default 8: register and operand-field width in bits (N >= 3).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: begin program run; sampled only in IDLE.
REQ-005 SHALL have port adr, output, 3 bits: program memory address (the PC).
REQ-006 SHALL have port instr, input, 3N+3 bits: memory word {op[2:0], dest[N], src1[N], src2[N]}, MSB first; valid combinationally for the current adr.
REQ-007 SHALL have port dbg_sel, input, 2 bits: register file read select.
REQ-008 SHALL have port dbg_data, output, N bits: reg[dbg_sel], combinational.
REQ-009 SHALL have port busy, output, 1 bit: high in FETCH and EXEC.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-011 SHALL have port carry, output, 1 bit: flag from the last ADD/SUB.

Function
REQ-012 SHALL contain 4 N-bit registers reg0..reg3; the index is the low 2 bits of a dest/src field, and upper field bits are ignored.
REQ-013 SHALL implement FSM states IDLE, FETCH, EXEC, DONE.
REQ-014 IDLE: start=1 -> FETCH; pc<=0, reg0..reg3<=0, carry<=0; start=0 -> stay in IDLE.
REQ-015 FETCH: SHALL latch instr into the internal instruction register ir; -> EXEC.
REQ-016 EXEC: SHALL execute ir; if op==HALT or pc==7 -> DONE, else pc<=pc+1 and -> FETCH.
REQ-017 adr SHALL equal pc at all times; pc SHALL NOT wrap in a run (address 7 is the last instruction).
REQ-018 Opcode 000 MOVI: reg[dest] <= src1 field (the full N-bit immediate).
REQ-019 Opcode 001 MOVR: reg[dest] <= reg[src1].
REQ-020 Opcode 010 ADD: {carry, reg[dest]} <= reg[src1] + reg[src2]; the sum wraps mod 2^N.
REQ-021 Opcode 011 SUB: reg[dest] <= reg[src1] - reg[src2] mod 2^N; carry <= borrow (src1 < src2).
REQ-022 Opcode 100 AND, 101 OR: bitwise on reg[src1], reg[src2] into reg[dest]; carry unchanged.
REQ-023 Opcode 110 NOP: no register change; opcode 111 HALT: no register change, run ends.
REQ-024 Operand reads in EXEC SHALL use pre-edge register values, so dest==src is legal (e.g. ADD r1,r1,r1 doubles r1).
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE. Registers and carry hold until the next start.
REQ-026 start asserted while busy or in DONE SHALL be ignored.
REQ-027 Each instruction SHALL take 2 cycles (FETCH+EXEC); a full 8-word run takes 16 busy cycles, then 1 DONE cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, pc/adr=0, reg0..reg3=0, carry=0, busy=0, done=0.
REQ-029 Reset mid-run SHALL abort the run with no done pulse; the next start SHALL restart from address 0.
REQ-030 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-031 Default program (0: MOVI r0,5; 1: MOVI r1,7; 2: ADD r2,r0,r1; 3-7: all-zero words), start pulse -> busy for 16 cycles, done pulse; final r0=0 (zero word = MOVI r0,0), r1=7, r2=12, r3=0, carry=0.
REQ-032 N=8, MOVI r0,200; MOVI r1,100; ADD r2,r0,r1; HALT at 3 -> r2=44, carry=1, done after 8 busy cycles, adr stops at 3.
REQ-033 MOVI r0,3; MOVI r1,5; SUB r2,r0,r1; HALT -> r2=254 (N=8), carry=1; SUB r3,r1,r0 variant -> r3=2, carry=0.
REQ-034 MOVI r1,6; ADD r1,r1,r1; MOVR r3,r1; HALT -> r1=12, r3=12; dest field 0x05 addresses r1.
REQ-035 rst_n low during the EXEC of address 2 -> all registers 0 and adr=0 without waiting for clk; no done pulse; a fresh start rerun gives the REQ-031 result.
REQ-036 start held high for the whole run -> exactly one run and one done pulse; a new run starts only on start sampled in IDLE afterwards.
